sram_mem_ctrl: RTL and testbench

Memory-stage controller that sequences multi-cycle accesses from the Mem stage of the five-stage ARM pipeline to an external 16-bit asynchronous SRAM. It splits each 32-bit load/store into two half-word SRAM phases, and stalls the pipeline while the access is in flight by deasserting `ready`. The top level drives `freeze` from `~ready`. Sits between the Exe_Stage_Reg outputs (ALU_Res, Val_Rm, MEM_R_EN, MEM_W_EN) and the Mem_Stage_Reg.

---
 rtl/sram_mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// Mem-stage controller for a 16-bit asynchronous SRAM. Each 32-bit load/store runs as two
// half-word phases (LO then HI), each WAIT_CYCLES+1 cycles long. ready=0 freezes the pipeline.
// Optional: define MEM_ADDR_CHECK_EN to reject out-of-range or misaligned accesses with err.
module sram_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned MEM_BASE    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic                   err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in
);

  // Word address width: one bit less than the half-word address.
  localparam int unsigned WaW = SRAM_ADDR_W - 1;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [WaW-1:0]         wa_q, wa_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic [15:0]            lo_q, lo_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic                   we_n_q, we_n_d, oe_n_q, oe_n_d, dq_oe_q, dq_oe_d;
  logic [15:0]            dq_out_q, dq_out_d;

  logic        req, bad, phase_end, in_phase_d;
  logic [31:0] offset;
  logic [29:0] wa_full;
  logic        unused_bits;

  assign req       = rd_en | wr_en;
  assign offset    = address - MEM_BASE;
  assign wa_full   = offset[31:2];
  assign phase_end = (cnt_q == 3'(WAIT_CYCLES));

`ifdef MEM_ADDR_CHECK_EN
  logic err_q, err_d;
  assign bad = (address < MEM_BASE) || (address[1:0] != 2'b00) || ((wa_full >> WaW) != '0);
  assign err = err_q;
  assign err_d = (state_q == StIdle) && req && bad;
  assign unused_bits = ^offset[1:0];

  // Error pulse: set on the IDLE->DONE edge of a rejected request, cleared one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  assign bad = 1'b0;
  assign err = 1'b0;
  assign unused_bits = ^{offset[1:0], wa_full[29:WaW]};
`endif

  // Next-state, request latching and read-data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 3'd1;
    wa_d        = wa_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    lo_d        = lo_q;
    read_data_d = read_data_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req) begin
          wa_d    = wa_full[WaW-1:0];
          wdata_d = write_data;
          wr_d    = wr_en;  // rd_en & wr_en resolves to a write
          state_d = bad ? StDone : StLo;
          if (bad && !wr_en) read_data_d = '0;
        end
      end
      StLo: begin
        if (phase_end) begin
          state_d = StHi;
          cnt_d   = '0;
          lo_d    = sram_dq_in;
        end
      end
      StHi: begin
        if (phase_end) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!wr_q) read_data_d = {sram_dq_in, lo_q};
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM pin values for the state being entered, so they switch on the phase-entry edge.
  always_comb begin
    in_phase_d  = (state_d == StLo) || (state_d == StHi);
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    if (in_phase_d) begin
      sram_addr_d = {wa_d, state_d == StHi};
      we_n_d      = ~wr_d;
      oe_n_d      = wr_d;
      dq_oe_d     = wr_d;
      if (wr_d) dq_out_d = (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
    end
  end

  // Freeze while a phase runs or a request is about to be accepted.
  always_comb begin
    ready = !((state_q == StLo) || (state_q == StHi) || ((state_q == StIdle) && req));
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wa_q        <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      lo_q        <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wa_q        <= wa_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      lo_q        <= lo_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_dq_out = dq_out_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: instance a uses WAIT_CYCLES=1, instance b WAIT_CYCLES=0.
// Each instance talks to a small behavioural SRAM array.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
  logic [31:0] a_address = 0, a_wdata = 0, b_address = 0, b_wdata = 0;
  logic [31:0] a_read_data, b_read_data;
  logic        a_ready, a_err, a_we_n, a_oe_n, a_dq_oe;
  logic        b_ready, b_err, b_we_n, b_oe_n, b_dq_oe;
  logic [17:0] a_sram_addr, b_sram_addr;
  logic [15:0] a_dq_out, b_dq_out, a_dq_in, b_dq_in;

  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];

  int checks = 0;
  int failures = 0;
  logic sel = 1'b0;

  sram_mem_ctrl #(.WAIT_CYCLES(1), .SRAM_ADDR_W(18), .MEM_BASE(1024)) dut_a (
    .clk(clk), .rst(rst), .rd_en(a_rd), .wr_en(a_wr), .address(a_address),
    .write_data(a_wdata), .read_data(a_read_data), .ready(a_ready), .err(a_err),
    .sram_addr(a_sram_addr), .sram_we_n(a_we_n), .sram_oe_n(a_oe_n),
    .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe), .sram_dq_in(a_dq_in)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(0), .SRAM_ADDR_W(18), .MEM_BASE(1024)) dut_b (
    .clk(clk), .rst(rst), .rd_en(b_rd), .wr_en(b_wr), .address(b_address),
    .write_data(b_wdata), .read_data(b_read_data), .ready(b_ready), .err(b_err),
    .sram_addr(b_sram_addr), .sram_we_n(b_we_n), .sram_oe_n(b_oe_n),
    .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in)
  );

  // Behavioural SRAMs: write while we_n low and the pad is driven, read combinationally.
  always @(posedge clk) begin
    if (!a_we_n && a_dq_oe) mem_a[a_sram_addr[5:0]] <= a_dq_out;
    if (!b_we_n && b_dq_oe) mem_b[b_sram_addr[5:0]] <= b_dq_out;
  end
  assign a_dq_in = !a_oe_n ? mem_a[a_sram_addr[5:0]] : 16'h0000;
  assign b_dq_in = !b_oe_n ? mem_b[b_sram_addr[5:0]] : 16'h0000;

  // Selected-instance views used by the access task.
  logic        m_ready, m_we_n, m_oe_n, m_err;
  logic [17:0] m_addr;
  logic [31:0] m_read_data;
  assign m_ready     = sel ? b_ready : a_ready;
  assign m_we_n      = sel ? b_we_n : a_we_n;
  assign m_oe_n      = sel ? b_oe_n : a_oe_n;
  assign m_err       = sel ? b_err : a_err;
  assign m_addr      = sel ? b_sram_addr : a_sram_addr;
  assign m_read_data = sel ? b_read_data : a_read_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on the selected instance for a single cycle, then run until ready
  // returns. Leaves the bench at the DONE-cycle sample point. Counts freeze cycles and strobes.
  task automatic access(input logic s, input logic w, input logic r, input logic [31:0] addr,
                        input logic [31:0] data, output int rl, output int wl0,
                        output int wl1, output int ol);
    rl = 0; wl0 = 0; wl1 = 0; ol = 0;
    @(negedge clk);
    sel = s;
    if (s) begin b_wr = w; b_rd = r; b_address = addr; b_wdata = data; end
    else   begin a_wr = w; a_rd = r; a_address = addr; a_wdata = data; end
    #1;
    if (!m_ready) rl++;
    @(negedge clk);
    a_wr = 0; a_rd = 0; a_address = 32'hFFFF_FFFF; a_wdata = 32'h5A5A_5A5A;
    b_wr = 0; b_rd = 0; b_address = 32'hFFFF_FFFF; b_wdata = 32'h5A5A_5A5A;
    for (int i = 0; i < 20; i++) begin
      if (m_ready) break;
      rl++;
      if (!m_we_n && !m_addr[0]) wl0++;
      if (!m_we_n && m_addr[0]) wl1++;
      if (!m_oe_n) ol++;
      @(negedge clk);
    end
    chk("access_completes", {31'd0, m_ready}, 32'd1);
  endtask

  int rl, wl0, wl1, ol;

  initial begin
    #22 rst = 1'b1;
    @(negedge clk);
    // Reset state.
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_read_data", a_read_data, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_sram_addr", {14'd0, a_sram_addr}, 32'd0);
    chk("rst_we_n", {31'd0, a_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, a_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, a_dq_oe}, 32'd0);
    chk("rst_dq_out", {16'd0, a_dq_out}, 32'd0);

    // W=1 store 0xDEADBEEF to 1024.
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, rl, wl0, wl1, ol);
    chk("st_freeze", rl, 5);
    chk("st_we_lo", wl0, 2);
    chk("st_we_hi", wl1, 2);
    chk("st_oe", ol, 0);
    chk("st_done_we_n", {31'd0, a_we_n}, 32'd1);
    chk("st_done_dq_oe", {31'd0, a_dq_oe}, 32'd0);
    chk("st_mem0", {16'd0, mem_a[0]}, 32'h0000_BEEF);
    chk("st_mem1", {16'd0, mem_a[1]}, 32'h0000_DEAD);

    // W=1 load back from 1024.
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'd0, rl, wl0, wl1, ol);
    chk("ld_freeze", rl, 5);
    chk("ld_oe", ol, 4);
    chk("ld_we", wl0 + wl1, 0);
    chk("ld_data", a_read_data, 32'hDEAD_BEEF);

    // W=0 simultaneous rd/wr at 1028 is a write to half-words 2 and 3.
    access(1'b1, 1'b1, 1'b1, 32'd1028, 32'h1234_5678, rl, wl0, wl1, ol);
    chk("w0_freeze", rl, 3);
    chk("w0_we_lo", wl0, 1);
    chk("w0_we_hi", wl1, 1);
    chk("w0_oe", ol, 0);
    chk("w0_mem2", {16'd0, mem_b[2]}, 32'h0000_5678);
    chk("w0_mem3", {16'd0, mem_b[3]}, 32'h0000_1234);
    access(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, rl, wl0, wl1, ol);
    chk("w0_ld_freeze", rl, 3);
    chk("w0_ld_data", b_read_data, 32'h1234_5678);

    // Reset during the HI phase of a W=1 store.
    @(negedge clk);
    sel = 1'b0;
    a_wr = 1; a_address = 32'd1032; a_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    a_wr = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_hi_addr", {14'd0, a_sram_addr}, 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we_n", {31'd0, a_we_n}, 32'd1);
    chk("mid_rst_ready", {31'd0, a_ready}, 32'd1);
    chk("mid_rst_read_data", a_read_data, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, a_ready}, 32'd1);
    chk("post_rst_we_n", {31'd0, a_we_n}, 32'd1);
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'd0, rl, wl0, wl1, ol);
    chk("post_rst_ld_freeze", rl, 5);
    chk("post_rst_ld_data", a_read_data, 32'hDEAD_BEEF);

    // Misaligned load from 1026.
    access(1'b0, 1'b0, 1'b1, 32'd1026, 32'd0, rl, wl0, wl1, ol);
`ifdef MEM_ADDR_CHECK_EN
    chk("mis_freeze", rl, 1);
    chk("mis_oe", ol, 0);
    chk("mis_err", {31'd0, m_err}, 32'd1);
    chk("mis_data", m_read_data, 32'd0);
`else
    chk("mis_freeze", rl, 5);
    chk("mis_oe", ol, 4);
    chk("mis_err", {31'd0, m_err}, 32'd0);
    chk("mis_data", m_read_data, 32'hDEAD_BEEF);
`endif
    @(negedge clk);
    chk("err_cleared", {31'd0, a_err}, 32'd0);

    // Word offset 2^17 wraps to half-word 0 unless range checking rejects it.
    access(1'b0, 1'b0, 1'b1, 32'd525312, 32'd0, rl, wl0, wl1, ol);
`ifdef MEM_ADDR_CHECK_EN
    chk("wrap_err", {31'd0, m_err}, 32'd1);
    chk("wrap_data", m_read_data, 32'd0);
`else
    chk("wrap_err", {31'd0, m_err}, 32'd0);
    chk("wrap_data", m_read_data, 32'hDEAD_BEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
